fifo_ring: RTL and testbench

- Parametrised synchronous FIFO built on a circular buffer with wrapping read/write pointers. It is the next generation of the team's shift-register FIFO and needs no data shifting.
- Adds simultaneous read+write in one cycle, an occupancy output, programmable almost-full/almost-empty flags and non-power-of-two depth.
- Sits between a producer and a consumer in the same clock domain, using the team's rd_en/rd_val, wr_en/wr_ready handshake.

---
 rtl/fifo_ring_pkg.sv | 11 +
 rtl/fifo_ring_if.sv | 25 ++
 rtl/fifo_ring_mem.sv | 24 ++
 rtl/fifo_ring.sv | 67 ++++++
 tb/tb_fifo_ring.sv | 120 ++++++++++++
 5 files changed

// File: rtl/fifo_ring_pkg.sv
// fifo_pkg: shared FIFO defaults, occupancy-width expression and wrapping pointer increment
package fifo_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction
  function automatic int ptr_next(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction
endpackage

// File: rtl/fifo_ring_if.sv
// fifo_ring_if: producer/consumer handshake, occupancy and error flags of the ring FIFO
interface fifo_ring_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH = 3
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ready;
  logic                  rd_en;
  logic                  rd_val;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [CNT_WIDTH-1:0]  count;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  overflow;
  logic                  underflow;
  modport master (
    output wr_en, wr_data, rd_en,
    input  wr_ready, rd_val, rd_data, count, almost_full, almost_empty, overflow, underflow
  );
  modport slave (
    input  wr_en, wr_data, rd_en,
    output wr_ready, rd_val, rd_data, count, almost_full, almost_empty, overflow, underflow
  );
endinterface

// File: rtl/fifo_ring_mem.sv
// fifo_ring_mem: unreset register array with one synchronous write port and a registered read port
module fifo_ring_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW = 2
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [AW-1:0]         i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) o_rdata <= '0;
    else if (i_re) o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/fifo_ring.sv
// fifo_ring: circular-buffer FIFO with occupancy and almost flags, any depth >= 2
// FIFO_RING_ERR_EN adds sticky overflow/underflow flags; otherwise they read 0.
module fifo_ring import fifo_pkg::*; #(
  parameter int DATA_WIDTH = DEF_WIDTH,
  parameter int FIFO_DEPTH = DEF_DEPTH,
  parameter int CNT_WIDTH = cnt_width(FIFO_DEPTH),
  parameter int AFULL_LVL = FIFO_DEPTH - 1,
  parameter int AEMPTY_LVL = 1
)(
  input logic clk,
  input logic reset,
  fifo_ring_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0] AFULL_C = CNT_WIDTH'(AFULL_LVL);
  localparam logic [CNT_WIDTH-1:0] AEMPTY_C = CNT_WIDTH'(AEMPTY_LVL);
  logic [PW-1:0]        r_wr_ptr, r_rd_ptr;
  logic [CNT_WIDTH-1:0] r_count;
  logic                 w_wr_acc, w_rd_acc;
  assign bus.wr_ready = r_count < DEPTH_C;
  assign bus.rd_val = r_count != '0;
  assign bus.almost_full = r_count >= AFULL_C;
  assign bus.almost_empty = r_count <= AEMPTY_C;
  assign bus.count = r_count;
  assign w_wr_acc = bus.wr_en & bus.wr_ready;
  assign w_rd_acc = bus.rd_en & bus.rd_val;
  // both accepted only when 0 < count < depth, so the pointers cannot alias
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= PW'(ptr_next(int'(r_wr_ptr), FIFO_DEPTH));
      if (w_rd_acc) r_rd_ptr <= PW'(ptr_next(int'(r_rd_ptr), FIFO_DEPTH));
      r_count <= r_count + CNT_WIDTH'(w_wr_acc) - CNT_WIDTH'(w_rd_acc);
    end
  end
  fifo_ring_mem #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH), .AW(PW)) u_mem (
    .clk     (clk),
    .rst     (reset),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr),
    .i_wdata (bus.wr_data),
    .i_re    (w_rd_acc),
    .i_raddr (r_rd_ptr),
    .o_rdata (bus.rd_data)
  );
`ifdef FIFO_RING_ERR_EN
  logic r_ovf, r_unf;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (bus.wr_en & ~bus.wr_ready) r_ovf <= 1'b1;
      if (bus.rd_en & ~bus.rd_val) r_unf <= 1'b1;
    end
  end
  assign bus.overflow = r_ovf;
  assign bus.underflow = r_unf;
`else
  assign bus.overflow = 1'b0;
  assign bus.underflow = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_ring.sv
// tb_fifo_ring: directed scoreboard bench for fifo_ring (depth 4, afull 3, aempty 1)
module tb_fifo_ring;
`ifdef FIFO_RING_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  int mc = 0;
  logic [7:0] exp_rd = 8'h00;
  bit eo = 1'b0;
  bit eu = 1'b0;
  logic [7:0] sb[$];
  always #5 clk = ~clk;
  fifo_ring_if #(.DATA_WIDTH(8), .CNT_WIDTH(3)) bus ();
  fifo_ring #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .AFULL_LVL(3), .AEMPTY_LVL(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_all(input string tag);
    chk({tag, ".count"}, 32'(bus.count), 32'(mc));
    chk({tag, ".rd_val"}, 32'(bus.rd_val), 32'(mc > 0));
    chk({tag, ".wr_ready"}, 32'(bus.wr_ready), 32'(mc < 4));
    chk({tag, ".afull"}, 32'(bus.almost_full), 32'(mc >= 3));
    chk({tag, ".aempty"}, 32'(bus.almost_empty), 32'(mc <= 1));
    chk({tag, ".rd_data"}, 32'(bus.rd_data), 32'(exp_rd));
    chk({tag, ".overflow"}, 32'(bus.overflow), 32'(ERR & eo));
    chk({tag, ".underflow"}, 32'(bus.underflow), 32'(ERR & eu));
  endtask
  task automatic cyc(input string tag, input bit we, input logic [7:0] wd, input bit re);
    bit wacc, racc;
    bus.wr_en = we;
    bus.wr_data = wd;
    bus.rd_en = re;
    wacc = we && mc < 4;
    racc = re && mc > 0;
    if (we && mc == 4) eo = 1'b1;
    if (re && mc == 0) eu = 1'b1;
    @(posedge clk);
    #1;
    if (racc) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $error("FAIL %s.scoreboard observed=empty expected=entry", tag);
      end else exp_rd = sb.pop_front();
    end
    if (wacc) sb.push_back(wd);
    mc = mc + int'(wacc) - int'(racc);
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    chk_all(tag);
  endtask
  initial begin
    bus.wr_en = 1'b0;
    bus.wr_data = 8'h00;
    bus.rd_en = 1'b0;
    #2;
    chk_all("reset");
    @(negedge clk);
    reset = 1'b0;
    foreach (sb[i]) sb.delete(i);
    cyc("fill0", 1, 8'h11, 0);
    cyc("fill1", 1, 8'h22, 0);
    cyc("fill2", 1, 8'h33, 0);
    cyc("fill3", 1, 8'h44, 0);
    cyc("wr_full", 1, 8'h55, 0);
    cyc("idle_full", 0, 8'h00, 0);
    for (int i = 0; i < 4; i++) cyc("drain", 0, 8'h00, 1);
    cyc("rd_empty", 0, 8'h00, 1);
    for (int i = 0; i < 3; i++) cyc("wrap_w0", 1, 8'(8'h01 + i), 0);
    for (int i = 0; i < 3; i++) cyc("wrap_r0", 0, 8'h00, 1);
    for (int i = 0; i < 3; i++) cyc("wrap_w1", 1, 8'(8'hA0 + i), 0);
    for (int i = 0; i < 3; i++) cyc("wrap_r1", 0, 8'h00, 1);
    cyc("sim_pre0", 1, 8'hB0, 0);
    cyc("sim_pre1", 1, 8'hB1, 0);
    for (int i = 0; i < 5; i++) cyc("sim_both", 1, 8'(8'hC0 + i), 1);
    cyc("sim_fill0", 1, 8'hD0, 0);
    cyc("sim_fill1", 1, 8'hD1, 0);
    cyc("both_full", 1, 8'hE0, 1);
    for (int i = 0; i < 3; i++) cyc("sim_drain", 0, 8'h00, 1);
    cyc("both_empty", 1, 8'hE1, 1);
    cyc("post_empty_rd", 0, 8'h00, 1);
    cyc("re_fill0", 1, 8'h71, 0);
    cyc("re_fill1", 1, 8'h72, 0);
    cyc("re_fill2", 1, 8'h73, 0);
    bus.wr_en = 1'b1;
    bus.wr_data = 8'h74;
    bus.rd_en = 1'b1;
    #3;
    reset = 1'b1;
    #1;
    mc = 0;
    exp_rd = 8'h00;
    eo = 1'b0;
    eu = 1'b0;
    sb.delete();
    chk_all("async_rst");
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    cyc("post_rst_w", 1, 8'h5A, 0);
    cyc("post_rst_r", 0, 8'h00, 1);
    cyc("final_idle", 0, 8'h00, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
